// File: rtl/cdc_pkg.sv
// Constants and helpers shared by the clock-domain-crossing blocks.
package cdc_pkg;

    localparam int CDC_MIN_SYNC_STAGES = 2;

    // Bits needed to hold values 0..value-1. The result is never below 1, so it is always usable as a vector width.
    function automatic int cdc_clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: flop-chain synchroniser, stability filter, and registered level/rise/fall outputs.
module sync_filter_channel
    import cdc_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_data,
    input  logic i_filter_en,
    output logic o_data,
    output logic o_rise,
    output logic o_fall
);

    localparam int                CNT_W    = cdc_clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_data;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_sync;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_data_next;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Bit 0 is the metastability-catching flop and is read only by bit 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
        end
    end

    always_comb begin
        w_data_next = r_data;
        w_cnt_next  = '0;
        if (!i_filter_en) begin
            w_data_next = w_sync;
        end else if (w_sync == r_data) begin
            w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_data_next = w_sync;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= RESET_VALUE;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_cnt  <= w_cnt_next;
            r_rise <= ~r_data & w_data_next;
            r_fall <= r_data & ~w_data_next;
        end
    end

    assign o_data = r_data;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/multi_step_sync_filter.sv
// Multi-channel synchroniser with per-channel glitch filter and edge pulses, all in the in_clk domain.
module multi_step_sync_filter
    import cdc_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic [CHANNELS-1:0] in_data,
    input  logic                in_filter_en,
    output logic [CHANNELS-1:0] out_data,
    output logic [CHANNELS-1:0] out_rise,
    output logic [CHANNELS-1:0] out_fall
);

    if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $fatal(1, "multi_step_sync_filter: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
        $fatal(1, "multi_step_sync_filter: FILTER_CYCLES must be at least 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $fatal(1, "multi_step_sync_filter: CHANNELS must be at least 1");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sync_filter_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VALUE   (RESET_VALUE[g])
        ) u_ch (
            .i_clk       (in_clk),
            .i_rst_n     (in_rst_n),
            .i_data      (in_data[g]),
            .i_filter_en (in_filter_en),
            .o_data      (out_data[g]),
            .o_rise      (out_rise[g]),
            .o_fall      (out_fall[g])
        );
    end

endmodule

// File: tb/tb_multi_step_sync_filter.sv
// Bench for multi_step_sync_filter: scenario tasks plus a pulse scoreboard checked by a monitor.
module tb_multi_step_sync_filter;

    localparam int         CH      = 4;
    localparam int         SYNC    = 3;
    localparam int         FILT    = 4;
    localparam logic [3:0] RV      = 4'b1010;
    localparam int         LAT_BYP = SYNC + 1;
    localparam int         LAT_FLT = SYNC + FILT;

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic [CH-1:0] in_data;
    logic          in_filter_en;
    logic [CH-1:0] out_data;
    logic [CH-1:0] out_rise;
    logic [CH-1:0] out_fall;

    typedef struct {
        int ch;
        bit rise;
        int cyc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    multi_step_sync_filter #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .RESET_VALUE   (RV)
    ) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_data      (in_data),
        .in_filter_en (in_filter_en),
        .out_data     (out_data),
        .out_rise     (out_rise),
        .out_fall     (out_fall)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) cyc++;

    // Every pulse seen must match the oldest expected event: channel, direction, edge number.
    always @(posedge in_clk) begin
        #1;
        if (in_rst_n === 1'b1) begin
            total++;
            if ((out_rise & out_fall) !== '0) begin
                bad++;
                $display("FAIL both_pulses rise=%b fall=%b required no overlap", out_rise, out_fall);
            end
            for (int c = 0; c < CH; c++) begin
                if (out_rise[c] === 1'b1 || out_fall[c] === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse ch=%0d rise=%b fall=%b cyc=%0d required none",
                                 c, out_rise[c], out_fall[c], cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        if (c != mon_e.ch || out_rise[c] !== mon_e.rise || cyc != mon_e.cyc
                            || out_data[c] !== mon_e.rise) begin
                            bad++;
                            $display("FAIL pulse_event got ch=%0d rise=%b data=%b cyc=%0d required ch=%0d rise=%b cyc=%0d",
                                     c, out_rise[c], out_data[c], cyc, mon_e.ch, mon_e.rise, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic push_ev(input int ch, input bit rise, input int at);
        ev_t e;
        e.ch   = ch;
        e.rise = rise;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        in_rst_n     = 1'b1;
        in_data      = RV;
        in_filter_en = 1'b1;
        #2 in_rst_n  = 1'b0;
        repeat (3) @(negedge in_clk);
        total++;
        if (out_data !== RV || out_rise !== '0 || out_fall !== '0) begin
            bad++;
            $display("FAIL reset_state data=%b rise=%b fall=%b required data=%b no pulses",
                     out_data, out_rise, out_fall, RV);
        end
        in_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge in_clk);
            total++;
            if (out_data !== RV || out_rise !== '0 || out_fall !== '0) begin
                bad++;
                $display("FAIL reset_release i=%0d data=%b rise=%b fall=%b required data=%b no pulses",
                         i, out_data, out_rise, out_fall, RV);
            end
        end
    endtask

    task automatic test_bypass();
        int k;
        @(negedge in_clk);
        in_filter_en = 1'b0;
        @(negedge in_clk);
        k = cyc;
        in_data[0] = 1'b1;
        push_ev(0, 1'b1, k + LAT_BYP);
        repeat (LAT_BYP - 1) @(negedge in_clk);
        total++;
        if (out_data[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_before data0=%b required 0", out_data[0]);
        end
        @(negedge in_clk);
        total++;
        if (out_data[0] !== 1'b1 || out_rise[0] !== 1'b1) begin
            bad++;
            $display("FAIL bypass_edge data0=%b rise0=%b required 1 1", out_data[0], out_rise[0]);
        end
        @(negedge in_clk);
        total++;
        if (out_data[0] !== 1'b1 || out_rise[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_single data0=%b rise0=%b required 1 0", out_data[0], out_rise[0]);
        end
        k = cyc;
        in_data[0] = 1'b0;
        push_ev(0, 1'b0, k + LAT_BYP);
        repeat (LAT_BYP) @(negedge in_clk);
        total++;
        if (out_data[0] !== 1'b0 || out_fall[0] !== 1'b1) begin
            bad++;
            $display("FAIL bypass_fall data0=%b fall0=%b required 0 1", out_data[0], out_fall[0]);
        end
        repeat (3) @(negedge in_clk);
    endtask

    task automatic test_filter_latency();
        int k;
        in_filter_en = 1'b1;
        repeat (2) @(negedge in_clk);
        k = cyc;
        in_data[1] = 1'b0;
        push_ev(1, 1'b0, k + LAT_FLT);
        repeat (LAT_FLT - 1) @(negedge in_clk);
        total++;
        if (out_data[1] !== 1'b1) begin
            bad++;
            $display("FAIL filter_before data1=%b required 1", out_data[1]);
        end
        @(negedge in_clk);
        total++;
        if (out_data[1] !== 1'b0 || out_fall[1] !== 1'b1) begin
            bad++;
            $display("FAIL filter_edge data1=%b fall1=%b required 0 1", out_data[1], out_fall[1]);
        end
        @(negedge in_clk);
        total++;
        if (out_fall[1] !== 1'b0) begin
            bad++;
            $display("FAIL filter_single fall1=%b required 0", out_fall[1]);
        end
    endtask

    task automatic test_glitch();
        int k;
        int hi;
        in_data[2] = 1'b1;
        repeat (FILT - 1) @(negedge in_clk);
        in_data[2] = 1'b0;
        for (int i = 0; i < LAT_FLT + FILT + 4; i++) begin
            @(negedge in_clk);
            total++;
            if (out_data[2] !== 1'b0) begin
                bad++;
                $display("FAIL glitch_hold i=%0d data2=%b required 0", i, out_data[2]);
            end
        end
        k = cyc;
        in_data[2] = 1'b1;
        push_ev(2, 1'b1, k + LAT_FLT);
        repeat (FILT + 1) @(negedge in_clk);
        in_data[2] = 1'b0;
        push_ev(2, 1'b0, k + FILT + 1 + LAT_FLT);
        hi = 0;
        repeat (2 * LAT_FLT + FILT) begin
            @(negedge in_clk);
            if (out_data[2] === 1'b1) hi++;
        end
        total++;
        if (hi != FILT + 1) begin
            bad++;
            $display("FAIL glitch_pass_width high_cycles=%0d required %0d", hi, FILT + 1);
        end
    endtask

    task automatic test_mode_switch();
        int k;
        k = cyc;
        in_data[3] = 1'b0;
        repeat (SYNC + 2) @(negedge in_clk);
        total++;
        if (out_data[3] !== 1'b1) begin
            bad++;
            $display("FAIL mode_before data3=%b required 1", out_data[3]);
        end
        in_filter_en = 1'b0;
        push_ev(3, 1'b0, k + SYNC + 3);
        @(negedge in_clk);
        total++;
        if (out_data[3] !== 1'b0 || out_fall[3] !== 1'b1) begin
            bad++;
            $display("FAIL mode_switch data3=%b fall3=%b required 0 1", out_data[3], out_fall[3]);
        end
        in_filter_en = 1'b1;
        @(negedge in_clk);
        k = cyc;
        in_data[3] = 1'b1;
        push_ev(3, 1'b1, k + LAT_FLT);
        repeat (LAT_FLT - 1) @(negedge in_clk);
        total++;
        if (out_data[3] !== 1'b0) begin
            bad++;
            $display("FAIL mode_reenable_before data3=%b required 0", out_data[3]);
        end
        @(negedge in_clk);
        total++;
        if (out_data[3] !== 1'b1 || out_rise[3] !== 1'b1) begin
            bad++;
            $display("FAIL mode_reenable_edge data3=%b rise3=%b required 1 1", out_data[3], out_rise[3]);
        end
        repeat (2) @(negedge in_clk);
    endtask

    task automatic test_async_reset();
        @(negedge in_clk);
        in_data[0] = 1'b1;
        repeat (SYNC + 3) @(negedge in_clk);
        total++;
        if (out_data[0] !== 1'b0) begin
            bad++;
            $display("FAIL arst_before data0=%b required 0", out_data[0]);
        end
        #2 in_rst_n = 1'b0;
        #1;
        total++;
        if (out_data !== RV || out_rise !== '0 || out_fall !== '0) begin
            bad++;
            $display("FAIL arst_immediate data=%b rise=%b fall=%b required data=%b no pulses",
                     out_data, out_rise, out_fall, RV);
        end
        in_data = RV;
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge in_clk);
            total++;
            if (out_data !== RV || out_rise !== '0 || out_fall !== '0) begin
                bad++;
                $display("FAIL arst_release i=%0d data=%b rise=%b fall=%b required data=%b no pulses",
                         i, out_data, out_rise, out_fall, RV);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_filter_latency();
        test_glitch();
        test_mode_switch();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
